inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Streaming RV32 assembler: packs decoded fields (instID, rs1, rs2, rd, imm) into 32-bit words for
//  the same subset InstructionDecode accepts (ADDI, ADD, LUI, BNE, JAL, LW, SW). Used by the program
//  loader and the decode self-check bench. Writes words in sequence to instruction memory.
//  Unencodable requests are dropped and counted.
// PARAMETERS
//  ADDR_W   32  width of the output byte address
//  ERRCNT_W 8   width of the saturating drop counter
// PORTS
//  clk        in  1             clock
//  rst        in  1             asynchronous, active-high reset
//  start      in  1             begin a program; latch start_addr; go to RUN
//  start_addr in  ADDR_W        byte address of the first word (bits [1:0] forced to 0)
//  in_valid   in  1             field bundle valid
//  in_ready   out 1             encoder can accept
//  in_id      in  `InstIDDepth  instruction ID (`ID_ADDI .. `ID_SW)
//  in_rs1/in_rs2/in_rd in 5     register indices
//  in_imm     in  32            signed immediate, byte offset for BNE/JAL, full upper value for LUI
//  in_last    in  1             final instruction of the program
//  out_valid  out 1             encoded word valid (memory write request)
//  out_ready  in  1             memory accepts the word
//  out_inst   out 32            encoded instruction
//  out_addr   out ADDR_W        byte address for out_inst
//  done       out 1             program finished; held until next start
//  err        out 1             sticky: at least one bundle dropped since start
//  err_cnt    out ERRCNT_W      dropped bundles, saturating
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_inst=0, out_addr=0, done=0, err=0, err_cnt=0; in_ready=0.
//  FSM: IDLE -start-> RUN; RUN -(last bundle consumed and its word, if any, accepted)-> DONE.
//       DONE -start-> RUN. A start in any state clears done/err/err_cnt and reloads the address.
//       If start and in_valid arrive in the same cycle, start wins; the bundle is not consumed.
//  in_ready = (state==RUN) && !pending_last && (!out_valid || out_ready). Acceptance = in_valid&&in_ready.
//  Latency: one cycle. An accepted bundle appears as out_inst/out_valid on the next edge.
//   out_valid, out_inst and out_addr are held stable while out_valid && !out_ready.
//  out_addr: the word goes to the current write pointer. The pointer advances by 4 on each
//   out_valid&&out_ready and wraps modulo 2^ADDR_W.
//  Encoding: opcode and funct3 from defines.v. ADD uses funct7=0. Fields use the standard RV32I layouts:
//   I {imm[11:0],rs1,f3,rd,op}  R {7'b0,rs2,rs1,f3,rd,op}  U {imm[31:12],rd,op}
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}  B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//  Drop rules: a bundle is consumed with no word emitted, err set and err_cnt+1 (saturating) if
//   - the ID is not one of the 7 supported IDs;
//   - ADDI/LW/SW and imm is outside [-2048, 2047];
//   - BNE and (imm[0]!=0 or imm is outside [-4096, 4094]);
//   - JAL and (imm[0]!=0 or imm is outside [-2^20, 2^20-2]);
//   - LUI and imm[11:0]!=0.
//  The write pointer does not advance on a drop. A dropped last bundle still ends the program.
//  Fields an instruction does not use (e.g. rs2 for ADDI) are ignored.
//  Reset mid-program: the pending word is discarded and the FSM returns to IDLE.
// STRUCTURE
//  defines.v: opcode/funct3/ID constants (shared with InstructionDecode); add FUNCT7_ADD.
//  Sub-module inst_pack: combinational (id, rs1, rs2, rd, imm) -> (inst, legal), reusable in benches.
//  This module: FSM, output holding register, write pointer, error counter.
// TESTING
//  start(0x100); ADDI x1,x0,5 -> 0x00500093 @0x100; ADD x3,x1,x2 -> 0x002081B3 @0x104.
//  LUI x5,0x12345000 -> 0x123452B7; BNE x1,x2,-8 -> 0xFE209CE3; JAL x1,16 -> 0x010000EF.
//  LW x6,8(x2) -> 0x00812303; SW x6,12(x2) + in_last -> 0x00612623, then done=1, in_ready=0.
//  ADDI imm=2048, BNE imm=3, unknown ID, in order -> no words; err=1, err_cnt=3; next word reuses the address.
//  Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no bundle lost.
//  Assert rst with out_valid=1 -> all outputs reset; no word after release until start.
//  start_addr=0xFFFFFFFC, two words -> addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32 subset encoder: instruction IDs, opcodes, funct fields,
// FSM state type and an immediate range helper.
package inst_encoder_pkg;

  localparam int ID_W = 4;

  localparam logic [ID_W-1:0] ID_ADDI = 4'd1;
  localparam logic [ID_W-1:0] ID_ADD  = 4'd2;
  localparam logic [ID_W-1:0] ID_LUI  = 4'd3;
  localparam logic [ID_W-1:0] ID_BNE  = 4'd4;
  localparam logic [ID_W-1:0] ID_JAL  = 4'd5;
  localparam logic [ID_W-1:0] ID_LW   = 4'd6;
  localparam logic [ID_W-1:0] ID_SW   = 4'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [6:0] FUNCT7_ADD = 7'b0000000;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // True when v, read as two's complement, fits in a signed field of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    lo = -(32'sd1 <<< (bits - 1));
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input stream, encoded-word output stream and program status for inst_encoder.
interface inst_encoder_if #(parameter int ADDR_W = 32, parameter int ERRCNT_W = 8);
  import inst_encoder_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   start_addr;
  logic                in_valid;
  logic                in_ready;
  logic [ID_W-1:0]     in_id;
  logic [4:0]          in_rs1;
  logic [4:0]          in_rs2;
  logic [4:0]          in_rd;
  logic [31:0]         in_imm;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_inst;
  logic [ADDR_W-1:0]   out_addr;
  logic                done;
  logic                err;
  logic [ERRCNT_W-1:0] err_cnt;

  modport slave (
    input  start, start_addr, in_valid, in_id, in_rs1, in_rs2, in_rd, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_inst, out_addr, done, err, err_cnt
  );

  modport master (
    output start, start_addr, in_valid, in_id, in_rs1, in_rs2, in_rd, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, done, err, err_cnt
  );

endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational packer: decoded fields to an RV32I word plus a flag saying whether
// the request is encodable at all.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [ID_W-1:0] id,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [31:0]     imm,
  output logic [31:0]     inst,
  output logic            legal
);

  always_comb begin
    inst  = '0;
    legal = 1'b0;
    case (id)
      ID_ADDI: begin
        inst  = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
        legal = fits_signed(imm, 12);
      end
      ID_ADD: begin
        inst  = {FUNCT7_ADD, rs2, rs1, F3_ADD, rd, OP_REG};
        legal = 1'b1;
      end
      ID_LUI: begin
        inst  = {imm[31:12], rd, OP_LUI};
        legal = (imm[11:0] == 12'h000);
      end
      // Branch and jump offsets are even; bit 0 is not encoded and must be clear.
      ID_BNE: begin
        inst  = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OP_BRANCH};
        legal = !imm[0] && fits_signed(imm, 13);
      end
      ID_JAL: begin
        inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal = !imm[0] && fits_signed(imm, 21);
      end
      ID_LW: begin
        inst  = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
        legal = fits_signed(imm, 12);
      end
      ID_SW: begin
        inst  = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        legal = fits_signed(imm, 12);
      end
      default: begin
        inst  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32 assembler: encodes field bundles into sequential instruction-memory writes,
// dropping and counting unencodable requests.
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | accepting bundles and emitting words
//   DONE    | last bundle handled; held until the next start
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  inst_encoder_if.slave bus
);

  state_t                state_q, state_d;
  logic                  pend_last_q, pend_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [31:0] pk_inst;
  logic        pk_legal;
  logic        in_ready;
  logic        accept;
  logic        out_fire;
  logic        done;

  inst_pack u_pack (
    .id    (bus.in_id),
    .rs1   (bus.in_rs1),
    .rs2   (bus.in_rs2),
    .rd    (bus.in_rd),
    .imm   (bus.in_imm),
    .inst  (pk_inst),
    .legal (pk_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (accept && bus.in_last && !pk_legal) state_d = ST_DONE;
      else if (pend_last_q && out_fire)       state_d = ST_DONE;
    end
  end

  // start wins over a simultaneous bundle, so it is excluded from acceptance only
  always_comb begin
    in_ready = (state_q == ST_RUN) && !pend_last_q && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready && !bus.start;
    out_fire = out_valid_q && bus.out_ready;
    done     = (state_q == ST_DONE);
  end

  // ptr_q is the address the next emitted word will take; drops leave it untouched
  always_comb begin
    pend_last_d = pend_last_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
      pend_last_d = 1'b0;
    end
    if (bus.start) begin
      ptr_d       = {bus.start_addr[ADDR_W-1:2], 2'b00};
      pend_last_d = 1'b0;
      err_d       = 1'b0;
      err_cnt_d   = '0;
    end else if (accept) begin
      if (pk_legal) begin
        out_valid_d = 1'b1;
        out_inst_d  = pk_inst;
        out_addr_d  = ptr_q;
        ptr_d       = ptr_q + ADDR_W'(4);
        pend_last_d = bus.in_last;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and randomized checks of inst_encoder against an arithmetic reference encoder
// and a word scoreboard.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_encoder_if bus ();

  inst_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [31:0] m_ptr = 32'h0;
  int          m_err = 0;
  bit          m_errflag = 1'b0;
  bit          acc = 1'b0;
  bit          rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from shifts and masks of the immediate value.
  function automatic bit ref_enc(input int id, input int rs1, input int rs2, input int rd,
                                 input logic [31:0] imm, output logic [31:0] w);
    longint      s;
    logic [31:0] u;
    s = longint'($signed(imm));
    u = imm;
    w = 32'h0;
    case (id)
      int'(ID_ADDI): begin
        if (s < -2048 || s > 2047) return 1'b0;
        w = ((u & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
      end
      int'(ID_ADD): w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      int'(ID_LUI): begin
        if (u % 4096 != 0) return 1'b0;
        w = u | (rd << 7) | 32'h37;
      end
      int'(ID_BNE): begin
        if (s % 2 != 0 || s < -4096 || s > 4094) return 1'b0;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
          | (1 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      int'(ID_JAL): begin
        if (s % 2 != 0 || s < -1048576 || s > 1048574) return 1'b0;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 255) << 12) | (rd << 7) | 32'h6f;
      end
      int'(ID_LW): begin
        if (s < -2048 || s > 2047) return 1'b0;
        w = ((u & 32'hfff) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
      end
      int'(ID_SW): begin
        if (s < -2048 || s > 2047) return 1'b0;
        w = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
          | ((u & 31) << 7) | 32'h23;
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // One clock: observe handshakes just before the edge, update the model, then step.
  task automatic tick();
    logic [31:0] w;
    bit          ok;
    exp_t        e;
    #1;
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      m_err = 0;
      m_errflag = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("word_inst", 64'(bus.out_inst), 64'(e.inst));
          check("word_addr", 64'(bus.out_addr), 64'(e.addr));
        end
      end
      if (bus.start) begin
        m_ptr = {bus.start_addr[31:2], 2'b00};
        m_err = 0;
        m_errflag = 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
        acc = 1'b1;
        ok = ref_enc(int'(bus.in_id), int'(bus.in_rs1), int'(bus.in_rs2), int'(bus.in_rd),
                     bus.in_imm, w);
        if (ok) begin
          sb.push_back('{inst: w, addr: m_ptr});
          m_ptr = m_ptr + 32'd4;
        end else begin
          m_errflag = 1'b1;
          if (m_err < 255) m_err++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst) check("err_cnt", 64'(bus.err_cnt), 64'(m_err));
  endtask

  task automatic set_in(input int id, input int rs1, input int rs2, input int rd,
                        input logic [31:0] imm, input bit last);
    bus.in_valid = 1'b1;
    bus.in_id    = ID_W'(id);
    bus.in_rs1   = 5'(rs1);
    bus.in_rs2   = 5'(rs2);
    bus.in_rd    = 5'(rd);
    bus.in_imm   = imm;
    bus.in_last  = last;
  endtask

  task automatic send(input int id, input int rs1, input int rs2, input int rd,
                      input logic [31:0] imm, input bit last);
    set_in(id, rs1, rs2, rd, imm, last);
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("bundle_accepted", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] addr);
    bus.start      = 1'b1;
    bus.start_addr = addr;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] inst, input logic [31:0] addr);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_inst"}, 64'(bus.out_inst), 64'(inst));
    check({tag, "_addr"}, 64'(bus.out_addr), 64'(addr));
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_inst"}, 64'(bus.out_inst), 64'd0);
    check({tag, "_out_addr"}, 64'(bus.out_addr), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    int          bnd[13];
    logic [31:0] imm;
    int          id;
    bnd = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 1048574, 1048576,
            -1048576, -1048578, 4095};

    bus.start = 1'b0;
    bus.start_addr = 32'h0;
    bus.in_valid = 1'b0;
    bus.in_id = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_rd = '0;
    bus.in_imm = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);

    // Reference program, start address low bits are ignored.
    do_start(32'h0000_0101);
    check("run_in_ready", 64'(bus.in_ready), 64'd1);
    send(int'(ID_ADDI), 0, 0, 1, 32'd5, 1'b0);
    chk_word("addi", 32'h0050_0093, 32'h100);
    send(int'(ID_ADD), 1, 2, 3, 32'd0, 1'b0);
    chk_word("add", 32'h0020_81B3, 32'h104);
    send(int'(ID_LUI), 0, 0, 5, 32'h1234_5000, 1'b0);
    chk_word("lui", 32'h1234_52B7, 32'h108);
    send(int'(ID_BNE), 1, 2, 0, -32'sd8, 1'b0);
    chk_word("bne", 32'hFE20_9CE3, 32'h10C);
    send(int'(ID_JAL), 0, 0, 1, 32'd16, 1'b0);
    chk_word("jal", 32'h0100_00EF, 32'h110);
    send(int'(ID_LW), 2, 0, 6, 32'd8, 1'b0);
    chk_word("lw", 32'h0081_2303, 32'h114);
    send(int'(ID_SW), 2, 6, 0, 32'd12, 1'b1);
    chk_word("sw", 32'h0061_2623, 32'h118);
    tick();
    check("prog_done", 64'(bus.done), 64'd1);
    check("done_in_ready", 64'(bus.in_ready), 64'd0);
    check("prog_err", 64'(bus.err), 64'd0);

    // Unencodable requests are consumed without output.
    do_start(32'h0000_0200);
    check("restart_done", 64'(bus.done), 64'd0);
    send(int'(ID_ADDI), 0, 0, 1, 32'd2048, 1'b0);
    send(int'(ID_BNE), 1, 2, 0, 32'd3, 1'b0);
    send(0, 1, 2, 3, 32'd0, 1'b0);
    check("drop_no_word", 64'(bus.out_valid), 64'd0);
    check("drop_err", 64'(bus.err), 64'd1);
    check("drop_err_cnt", 64'(bus.err_cnt), 64'd3);
    send(int'(ID_ADDI), 0, 0, 1, 32'd1, 1'b0);
    chk_word("after_drop", 32'h0010_0093, 32'h200);
    tick();

    // Back-pressure: word held, next bundle waits.
    bus.out_ready = 1'b0;
    send(int'(ID_ADD), 4, 5, 6, 32'd0, 1'b0);
    set_in(int'(ID_LW), 7, 0, 8, 32'hFFFF_FFFC, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_out_inst", 64'(bus.out_inst), 64'(sb[0].inst));
      check("bp_out_addr", 64'(bus.out_addr), 64'(sb[0].addr));
    end
    bus.out_ready = 1'b1;
    send(int'(ID_LW), 7, 0, 8, 32'hFFFF_FFFC, 1'b0);
    chk_word("bp_next", 32'hFFC3_A403, 32'h208);
    tick();
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Reset while a word is waiting.
    bus.out_ready = 1'b0;
    send(int'(ID_ADDI), 3, 0, 4, 32'd7, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_in(int'(ID_ADDI), 1, 0, 1, 32'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("post_rst_in_ready", 64'(bus.in_ready), 64'd0);
    end

    // Start wins over a same-cycle bundle; then address wrap.
    set_in(int'(ID_ADDI), 0, 0, 2, 32'd9, 1'b0);
    do_start(32'hFFFF_FFFC);
    check("start_wins_no_word", 64'(bus.out_valid), 64'd0);
    send(int'(ID_ADDI), 0, 0, 2, 32'd9, 1'b0);
    chk_word("wrap0", 32'h0090_0113, 32'hFFFF_FFFC);
    send(int'(ID_ADDI), 0, 0, 2, 32'd10, 1'b0);
    chk_word("wrap1", 32'h00A0_0113, 32'h0000_0000);
    tick();

    // Randomized program with random memory back-pressure.
    do_start($urandom() & 32'hFFFF_FFFC);
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      id = int'($urandom_range(0, 9));
      case ($urandom_range(0, 4))
        0: imm = 32'($signed($urandom_range(0, 4200)) - 2100);
        1: imm = $urandom() & 32'hFFFF_F000;
        2: imm = 32'($signed($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
        3: imm = $urandom();
        default: imm = 32'(bnd[$urandom_range(0, 12)]);
      endcase
      send(id, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), imm, i == 199);
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && !(bus.done && sb.size() == 0); k++) tick();
    check("rnd_done", 64'(bus.done), 64'd1);
    check("rnd_drained", 64'(sb.size()), 64'd0);
    check("rnd_err", 64'(bus.err), 64'(m_errflag));
    check("rnd_in_ready", 64'(bus.in_ready), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
